// File: rtl/pc_predictor.sv
// Fetch-PC generator with a direct-mapped BTB and 2-bit direction counters.
// Resolved EX outcomes train the BTB and force a redirect plus flush on misprediction.
module pc_predictor #(
    parameter int              XLEN        = 32,
    parameter int              ENTRIES     = 16,
    parameter logic [XLEN-1:0] RESET_PC    = {XLEN{1'b0}},
    parameter bit              PRED_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    output logic [XLEN-1:0] pc_out,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_is_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            flush,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     miss_cnt
);

    localparam int              IDX     = $clog2(ENTRIES);
    localparam int              TAGW    = XLEN - IDX - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

    function automatic logic [1:0] ctr_inc(input logic [1:0] c);
        ctr_inc = (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] ctr_dec(input logic [1:0] c);
        ctr_dec = (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic            valid_q  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic            jump_q   [ENTRIES];
    logic [1:0]      ctr_q    [ENTRIES];

    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     branch_cnt_q, branch_cnt_d;
    logic [31:0]     miss_cnt_q, miss_cnt_d;

    logic [IDX-1:0]  lk_idx_s, ex_idx_s;
    logic            lk_hit_s, ex_hit_s;
    logic            pred_taken_s;
    logic [XLEN-1:0] pred_target_s;
    logic            mis_s;
    logic [XLEN-1:0] redirect_s;
    logic            btb_alloc_s, ctr_we_s;
    logic [1:0]      ctr_d;

    assign lk_idx_s = pc_q[IDX+1:2];
    assign ex_idx_s = ex_pc[IDX+1:2];
    assign lk_hit_s = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == pc_q[XLEN-1:IDX+2]);
    assign ex_hit_s = valid_q[ex_idx_s] && (tag_q[ex_idx_s] == ex_pc[XLEN-1:IDX+2]);

    // Lookup on the current fetch PC; the static mode never predicts taken.
    always_comb begin
        pred_taken_s  = 1'b0;
        pred_target_s = pc_q + PC_STEP;
        if (PRED_ENABLE && lk_hit_s && (jump_q[lk_idx_s] || ctr_q[lk_idx_s][1])) begin
            pred_taken_s  = 1'b1;
            pred_target_s = target_q[lk_idx_s];
        end else begin
            pred_taken_s  = 1'b0;
        end
    end

    assign mis_s      = ex_valid && ((ex_taken != ex_pred_taken) ||
                                     (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_s = ex_taken ? ex_target : ex_pc + PC_STEP;

    // Next fetch PC: a redirect wins over stall, stall holds, else follow the prediction.
    always_comb begin
        pc_d = pred_target_s;
        if (mis_s) begin
            pc_d = redirect_s;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pred_target_s;
        end
    end

    // Performance counters, free-running regardless of stall.
    always_comb begin
        branch_cnt_d = branch_cnt_q + {31'd0, ex_valid};
        miss_cnt_d   = miss_cnt_q + {31'd0, mis_s};
    end

    // BTB training decision for the EX instruction's entry.
    always_comb begin
        btb_alloc_s = 1'b0;
        ctr_we_s    = 1'b0;
        ctr_d       = ctr_q[ex_idx_s];
        if (PRED_ENABLE && ex_valid) begin
            if (ex_taken) begin
                btb_alloc_s = 1'b1;
                ctr_d       = ex_hit_s ? ctr_inc(ctr_q[ex_idx_s]) : 2'b10;
            end else if (ex_hit_s) begin
                ctr_we_s = 1'b1;
                ctr_d    = ctr_dec(ctr_q[ex_idx_s]);
            end else begin
                ctr_we_s = 1'b0;
            end
        end else begin
            btb_alloc_s = 1'b0;
        end
    end

    // State update; reset discards any training pending in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            branch_cnt_q <= 32'd0;
            miss_cnt_q   <= 32'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAGW{1'b0}};
                target_q[i] <= {XLEN{1'b0}};
                jump_q[i]   <= 1'b0;
                ctr_q[i]    <= 2'b00;
            end
        end else begin
            pc_q         <= pc_d;
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            if (btb_alloc_s) begin
                valid_q[ex_idx_s]  <= 1'b1;
                tag_q[ex_idx_s]    <= ex_pc[XLEN-1:IDX+2];
                target_q[ex_idx_s] <= ex_target;
                jump_q[ex_idx_s]   <= ex_is_jump;
                ctr_q[ex_idx_s]    <= ctr_d;
            end else if (ctr_we_s) begin
                ctr_q[ex_idx_s]    <= ctr_d;
            end
        end
    end

    assign pc_out      = pc_q;
    assign pred_taken  = pred_taken_s;
    assign pred_target = pred_target_s;
    assign flush       = mis_s;
    assign branch_cnt  = branch_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: one predicting instance and one static instance
// share all stimulus; expected values are hand-derived constants.
module tb_pc_predictor;

    logic        clk = 1'b0;
    logic        rst, stall;
    logic        ex_valid, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;

    logic [31:0] pc_out, pred_target, branch_cnt, miss_cnt;
    logic        pred_taken, flush;
    logic [31:0] pc_out_s, pred_target_s, branch_cnt_s, miss_cnt_s;
    logic        pred_taken_s, flush_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_predictor #(.XLEN(32), .ENTRIES(16), .RESET_PC(32'h0), .PRED_ENABLE(1'b1)) u_dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pc_out(pc_out), .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush), .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    pc_predictor #(.XLEN(32), .ENTRIES(16), .RESET_PC(32'h0), .PRED_ENABLE(1'b0)) u_dut_static (
        .clk(clk), .rst(rst), .stall(stall),
        .pc_out(pc_out_s), .pred_taken(pred_taken_s), .pred_target(pred_target_s),
        .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_pc(ex_pc), .ex_taken(ex_taken),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush_s), .branch_cnt(branch_cnt_s), .miss_cnt(miss_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
        ex_valid       = 1'b1;
        ex_is_jump     = 1'b0;
        ex_pc          = pc;
        ex_taken       = tk;
        ex_target      = tgt;
        ex_pred_taken  = ptk;
        ex_pred_target = ptgt;
    endtask

    task automatic ex_clr();
        ex_valid       = 1'b0;
        ex_is_jump     = 1'b0;
        ex_pc          = 32'h0;
        ex_taken       = 1'b0;
        ex_target      = 32'h0;
        ex_pred_taken  = 1'b0;
        ex_pred_target = 32'h0;
    endtask

    // Mispredicted not-taken branch at 0xC: redirects fetch to 0x10 without touching index 4.
    task automatic goto_10();
        ex_set(32'h0C, 1'b0, 32'h0, 1'b1, 32'h0);
        tick();
        ex_clr();
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        ex_clr();
        tick();
        rst = 1'b0;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_ptaken", 32'(pred_taken), 32'd0);
        chk("rst_ptarget", pred_target, 32'h4);
        chk("rst_bcnt", branch_cnt, 32'd0);
        chk("rst_mcnt", miss_cnt, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("seq_pc", pc_out, 32'(4 * i));
        end

        // Cold taken branch at 0x10 -> 0x40
        ex_set(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
        #1 chk("cold_flush", 32'(flush), 32'd1);
        tick();
        ex_clr();
        chk("cold_pc", pc_out, 32'h40);
        chk("cold_mcnt", miss_cnt, 32'd1);
        chk("cold_bcnt", branch_cnt, 32'd1);
        goto_10();
        chk("hit_ptaken", 32'(pred_taken), 32'd1);
        chk("hit_ptarget", pred_target, 32'h40);
        tick();
        chk("zero_bubble_pc", pc_out, 32'h40);

        // Saturate to 3 with correctly predicted taken resolves
        for (int i = 0; i < 3; i++) begin
            ex_set(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
            #1 chk("sat_noflush", 32'(flush), 32'd0);
            tick();
        end
        ex_clr();
        chk("sat_bcnt", branch_cnt, 32'd5);
        chk("sat_mcnt", miss_cnt, 32'd2);

        ex_set(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
        #1 chk("nt1_flush", 32'(flush), 32'd1);
        tick();
        ex_clr();
        chk("nt1_pc", pc_out, 32'h14);
        goto_10();
        chk("nt1_ptaken", 32'(pred_taken), 32'd1);
        ex_set(32'h10, 1'b0, 32'h0, 1'b1, 32'h40);
        #1 chk("nt2_flush", 32'(flush), 32'd1);
        tick();
        ex_clr();
        chk("nt2_pc", pc_out, 32'h14);
        goto_10();
        chk("nt2_ptaken", 32'(pred_taken), 32'd0);
        chk("nt2_ptarget", pred_target, 32'h14);
        chk("nt2_bcnt", branch_cnt, 32'd9);
        chk("nt2_mcnt", miss_cnt, 32'd6);

        // Same-cycle lookup/update on index 4: lookup still sees ctr=1
        ex_set(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
        #1 chk("same_ptaken", 32'(pred_taken), 32'd0);
        chk("same_noflush", 32'(flush), 32'd0);
        tick();
        ex_clr();
        chk("same_pc", pc_out, 32'h14);

        // Alias 0x50 evicts 0x10
        ex_set(32'h50, 1'b1, 32'h90, 1'b0, 32'h0);
        #1 chk("alias_flush", 32'(flush), 32'd1);
        tick();
        ex_clr();
        chk("alias_pc", pc_out, 32'h90);
        goto_10();
        chk("alias_ptaken", 32'(pred_taken), 32'd0);
        chk("alias_bcnt", branch_cnt, 32'd12);
        chk("alias_mcnt", miss_cnt, 32'd8);

        // Stall hold, then redirect overriding stall
        stall = 1'b1;
        tick();
        chk("stall_pc1", pc_out, 32'h10);
        tick();
        chk("stall_pc2", pc_out, 32'h10);
        ex_set(32'h20, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        ex_clr();
        stall = 1'b0;
        chk("stall_redir_pc", pc_out, 32'h80);
        chk("stall_mcnt", miss_cnt, 32'd9);

        // Static-mode instance: cold taken branch four times
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("st_rst_pc", pc_out_s, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ex_set(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
            #1 chk("st_flush", 32'(flush_s), 32'd1);
            chk("st_ptaken", 32'(pred_taken_s), 32'd0);
            tick();
        end
        ex_clr();
        chk("st_mcnt", miss_cnt_s, 32'd4);
        chk("st_bcnt", branch_cnt_s, 32'd4);
        chk("st_pc", pc_out_s, 32'h40);
        goto_10();
        chk("st_pc10", pc_out_s, 32'h10);
        chk("st_ptaken10", 32'(pred_taken_s), 32'd0);
        chk("st_ptarget10", pred_target_s, 32'h14);
        chk("dyn_ptaken10", 32'(pred_taken), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
